// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, parity mode codes and
// the clocks-per-bit divisor calculation. Also intended for uart_tx_cfg.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received words ({tuser, tdata}).
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid, in_data    push side; a push while full is accepted only if a
//                        pop happens in the same cycle, otherwise dropped
//   full                 FIFO holds DEPTH words
//   out_valid, out_data  AXI-stream source, out_data is zero when empty
//   out_ready            downstream ready
module uart_rx_fifo #(
  parameter int AW = 2,
  parameter int W  = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         full,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign out_valid = (count != '0);
  assign full      = (count == (AW + 1)'(DEPTH));
  assign do_pop    = out_valid && out_ready;
  // Pop frees a slot in the same cycle, so a push on full is still taken.
  assign do_push   = in_valid && (!full || do_pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; out_data is gated by out_valid so
  // stale contents never reach the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS 5..8, none/odd/even parity, 1 or 2
// stop bits, mid-bit 2-of-3 majority sampling, false-start rejection, error
// tagging and an optional RX FIFO.
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   i_uart_rx    asynchronous serial line, idle high
//   o_tready     downstream ready
//   o_tvalid     received word valid
//   o_tdata      received word, zero-extended above DATA_BITS
//   o_tuser      {ferr, perr} for o_tdata
//   o_overflow   1-cycle pulse when a completed word is dropped
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_EA   = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_uart_rx,
  input  logic       o_tready,
  output logic       o_tvalid,
  output logic [7:0] o_tdata,
  output logic [1:0] o_tuser,
  output logic       o_overflow
);

  localparam int            DIV     = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int            CW      = $clog2(DIV) + 1;
  localparam logic [CW-1:0] HALF    = CW'(DIV / 2);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam int            FIFO_AW = (FIFO_EA < 3) ? 2 : FIFO_EA;

  // Synchroniser plus two history flops: majority over the three most recent
  // synchronised samples.
  logic sync1, sync2, hist1, hist2;
  logic maj, fall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so each flop takes the pre-edge value
      // of its predecessor and the chain really is a shift register.
      sync1 <= i_uart_rx;
      sync2 <= sync1;
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  assign maj  = (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
  assign fall = hist1 & ~sync2;

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par_acc, par_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 push;
  logic [9:0]           push_word;
  logic                 tick;
  logic                 f_tvalid;
  logic [9:0]           f_data;

  assign tick = (cnt == LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_cnt;
    sh_n      = sh;
    par_n     = par_acc;
    perr_n    = perr;
    ferr_n    = ferr;
    push      = 1'b0;
    push_word = '0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n = ST_START;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      ST_START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          if (maj) begin
            state_n = ST_IDLE;   // glitch, not a start bit
          end else begin
            state_n = ST_DATA;
            sh_n    = '0;
            par_n   = 1'b0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_n = '0;
          sh_n  = {maj, sh[DATA_BITS-1:1]};
          par_n = par_acc ^ maj;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_n   = '0;
            state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_PARITY: begin
        if (tick) begin
          cnt_n   = '0;
          perr_n  = ((par_acc ^ maj) != (PARITY == PARITY_ODD));
          state_n = ST_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_n  = '0;
          ferr_n = ferr | ~maj;
          if (bit_cnt == 4'(STOP_BITS - 1)) begin
            push      = 1'b1;
            push_word = {ferr_n, perr, 8'(sh)};
            bit_n     = '0;
            // A framing error may be a break: wait for the line to recover.
            state_n   = ferr_n ? ST_WAIT_HIGH : ST_IDLE;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (maj) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      par_acc  <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      f_tvalid <= 1'b0;
      f_data   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      sh       <= sh_n;
      par_acc  <= par_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
      f_tvalid <= push;
      if (push) f_data <= push_word;
    end
  end

  if (FIFO_EA == 0) begin : g_direct
    // Single-cycle strobe; o_tready only decides whether the word counts as lost.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        o_tvalid   <= 1'b0;
        o_tdata    <= '0;
        o_tuser    <= '0;
        o_overflow <= 1'b0;
      end else begin
        o_tvalid   <= f_tvalid;
        o_overflow <= f_tvalid & ~o_tready;
        if (f_tvalid) {o_tuser, o_tdata} <= f_data;
      end
    end
  end else begin : g_fifo
    logic       fifo_full;
    logic [9:0] fifo_out;

    uart_rx_fifo #(
      .AW (FIFO_AW),
      .W  (10)
    ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (f_tvalid),
      .in_data   (f_data),
      .full      (fifo_full),
      .out_valid (o_tvalid),
      .out_data  (fifo_out),
      .out_ready (o_tready)
    );

    assign {o_tuser, o_tdata} = fifo_out;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) o_overflow <= 1'b0;
      else       o_overflow <= f_tvalid & fifo_full & ~(o_tvalid & o_tready);
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg. Five receiver instances share clk/rstn:
//   d0 default 8N1 (DIV=434), d1 8E1, d2 7N2, d3 8N1 with FIFO_EA=2,
//   d4 8N1; d1..d4 run at DIV=16 to keep the run short.
module tb_uart_rx_cfg;

  localparam int FAST_CLK  = 1_600_000;
  localparam int FAST_BAUD = 100_000;   // DIV = 16
  localparam int NV        = 9;
  localparam int NNOISE    = 150;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] rx;
  logic [4:0] rdy;
  logic [4:0] tv;
  logic [4:0] ov;
  logic [7:0] td [5];
  logic [1:0] tu [5];

  logic [9:0] got   [5][256];
  int         got_n [5];
  int         ov_n  [5];
  int         n_vec = 0;
  int         n_err = 0;

  typedef struct {
    int          inst;
    int          div;
    logic [15:0] bits;     // LSB first, start bit in bit 0
    int          nb;
    logic        rdy;
    logic [9:0]  exp_word; // {ferr, perr, data}
    int          exp_ovf;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  uart_rx_cfg u_d0 (
    .clk(clk), .rstn(rstn), .i_uart_rx(rx[0]), .o_tready(rdy[0]),
    .o_tvalid(tv[0]), .o_tdata(td[0]), .o_tuser(tu[0]), .o_overflow(ov[0]));

  uart_rx_cfg #(.CLK_FREQ(FAST_CLK), .BAUD_RATE(FAST_BAUD), .PARITY(2)) u_d1 (
    .clk(clk), .rstn(rstn), .i_uart_rx(rx[1]), .o_tready(rdy[1]),
    .o_tvalid(tv[1]), .o_tdata(td[1]), .o_tuser(tu[1]), .o_overflow(ov[1]));

  uart_rx_cfg #(.CLK_FREQ(FAST_CLK), .BAUD_RATE(FAST_BAUD), .DATA_BITS(7), .STOP_BITS(2)) u_d2 (
    .clk(clk), .rstn(rstn), .i_uart_rx(rx[2]), .o_tready(rdy[2]),
    .o_tvalid(tv[2]), .o_tdata(td[2]), .o_tuser(tu[2]), .o_overflow(ov[2]));

  uart_rx_cfg #(.CLK_FREQ(FAST_CLK), .BAUD_RATE(FAST_BAUD), .FIFO_EA(2)) u_d3 (
    .clk(clk), .rstn(rstn), .i_uart_rx(rx[3]), .o_tready(rdy[3]),
    .o_tvalid(tv[3]), .o_tdata(td[3]), .o_tuser(tu[3]), .o_overflow(ov[3]));

  uart_rx_cfg #(.CLK_FREQ(FAST_CLK), .BAUD_RATE(FAST_BAUD)) u_d4 (
    .clk(clk), .rstn(rstn), .i_uart_rx(rx[4]), .o_tready(rdy[4]),
    .o_tvalid(tv[4]), .o_tdata(td[4]), .o_tuser(tu[4]), .o_overflow(ov[4]));

  // Record delivered words and overflow pulses away from the rising edge.
  // d3 is a stream source: a word counts only on the handshake.
  always @(negedge clk) begin
    if (rstn) begin
      for (int k = 0; k < 5; k++) begin
        if (tv[k] && (k != 3 || rdy[k])) begin
          if (got_n[k] < 256) got[k][got_n[k]] = {tu[k], td[k]};
          got_n[k]++;
        end
        if (ov[k]) ov_n[k]++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear(input int k);
    got_n[k] = 0;
    ov_n[k]  = 0;
  endtask

  // Drive one frame; with spike set, a one-clock inverted pulse sits at the
  // centre of the start bit and every data bit.
  task automatic send_bits(input int k, input int div, input logic [15:0] bits,
                           input int nb, input bit spike);
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < div; c++) begin
        rx[k] = (spike && i <= 8 && c == div / 2) ? ~bits[i] : bits[i];
        tick(1);
      end
    end
    rx[k] = 1'b1;
  endtask

  task automatic send_8n1(input int k, input int div, input logic [7:0] b, input bit spike);
    send_bits(k, div, 16'({1'b1, b, 1'b0}), 10, spike);
  endtask

  logic [7:0] noise_bytes [NNOISE];
  int         k;

  initial begin
    vecs[0] = '{0, 434, 16'({1'b1, 8'hA5, 1'b0}),       10, 1'b1, 10'h0A5, 0};
    vecs[1] = '{1, 16,  16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 1'b1, 10'h007, 0};
    vecs[2] = '{1, 16,  16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 1'b1, 10'h107, 0};
    vecs[3] = '{1, 16,  16'({1'b1, 1'b0, 8'hFF, 1'b0}), 11, 1'b1, 10'h0FF, 0};
    vecs[4] = '{1, 16,  16'({1'b0, 1'b1, 8'h07, 1'b0}), 11, 1'b1, 10'h207, 0};
    vecs[5] = '{2, 16,  16'({1'b0, 1'b1, 7'h55, 1'b0}), 11, 1'b1, 10'h255, 0};
    vecs[6] = '{2, 16,  16'({1'b1, 1'b1, 7'h2A, 1'b0}), 11, 1'b1, 10'h02A, 0};
    vecs[7] = '{4, 16,  16'({1'b1, 8'hC3, 1'b0}),       10, 1'b0, 10'h0C3, 1};
    vecs[8] = '{4, 16,  16'({1'b1, 8'h00, 1'b0}),       10, 1'b1, 10'h000, 0};

    for (int i = 0; i < 5; i++) clear(i);
    rx   = '1;
    rdy  = '1;
    rstn = 1'b0;
    tick(5);
    check("reset tvalid", 32'(tv), 32'h0);
    check("reset overflow", 32'(ov), 32'h0);
    check("reset d0 word", 32'({tu[0], td[0]}), 32'h0);
    check("reset d3 word", 32'({tu[3], td[3]}), 32'h0);
    rstn = 1'b1;
    tick(5);

    for (int i = 0; i < NV; i++) begin
      k = vecs[i].inst;
      clear(k);
      rdy[k] = vecs[i].rdy;
      send_bits(k, vecs[i].div, vecs[i].bits, vecs[i].nb, 1'b0);
      tick(2 * vecs[i].div);
      check($sformatf("vec%0d count", i), 32'(got_n[k]), 32'd1);
      if (got_n[k] > 0) check($sformatf("vec%0d word", i), 32'(got[k][0]), 32'(vecs[i].exp_word));
      check($sformatf("vec%0d overflow", i), 32'(ov_n[k]), 32'(vecs[i].exp_ovf));
      rdy[k] = 1'b1;
    end

    // Short low glitch on the idle line is rejected, next byte still arrives.
    clear(0);
    rx[0] = 1'b0;
    tick(100);
    rx[0] = 1'b1;
    tick(600);
    check("glitch no word", 32'(got_n[0]), 32'd0);
    send_8n1(0, 434, 8'h3C, 1'b0);
    tick(868);
    check("after glitch count", 32'(got_n[0]), 32'd1);
    if (got_n[0] > 0) check("after glitch word", 32'(got[0][0]), 32'h03C);

    // Break on the 7N2 receiver: one errored all-zero word, nothing more
    // until the line returns high.
    clear(2);
    rx[2] = 1'b0;
    tick(320);
    check("break count", 32'(got_n[2]), 32'd1);
    if (got_n[2] > 0) check("break word", 32'(got[2][0]), 32'h200);
    rx[2] = 1'b1;
    tick(32);
    check("break recovered count", 32'(got_n[2]), 32'd1);
    send_bits(2, 16, 16'({1'b1, 1'b1, 7'h11, 1'b0}), 11, 1'b0);
    tick(32);
    check("after break count", 32'(got_n[2]), 32'd2);
    if (got_n[2] > 1) check("after break word", 32'(got[2][1]), 32'h011);

    // FIFO depth 4: fifth byte dropped with a single overflow pulse.
    clear(3);
    rdy[3] = 1'b0;
    for (int b = 1; b <= 5; b++) send_8n1(3, 16, 8'(b), 1'b0);
    tick(32);
    check("fifo overflow pulses", 32'(ov_n[3]), 32'd1);
    check("fifo held valid", 32'(tv[3]), 32'd1);
    check("fifo held head", 32'({tu[3], td[3]}), 32'h001);
    rdy[3] = 1'b1;
    tick(10);
    check("fifo drain count", 32'(got_n[3]), 32'd4);
    for (int j = 0; j < 4 && j < got_n[3]; j++)
      check($sformatf("fifo word%0d", j), 32'(got[3][j]), 32'(j + 1));
    check("fifo empty valid", 32'(tv[3]), 32'd0);

    // Reset in the middle of the data bits of 0x81, then a clean 0x42.
    clear(0);
    rx[0] = 1'b0; tick(434);   // start
    rx[0] = 1'b1; tick(434);   // bit0 = 1
    rx[0] = 1'b0; tick(200);   // inside bit1
    rstn = 1'b0;
    tick(3);
    check("mid reset tvalid", 32'(tv), 32'h0);
    check("mid reset overflow", 32'(ov), 32'h0);
    check("mid reset d0 word", 32'({tu[0], td[0]}), 32'h0);
    rx[0] = 1'b1;
    tick(3);
    rstn = 1'b1;
    tick(20);
    send_8n1(0, 434, 8'h42, 1'b0);
    tick(868);
    check("post reset count", 32'(got_n[0]), 32'd1);
    if (got_n[0] > 0) check("post reset word", 32'(got[0][0]), 32'h042);

    // Random bytes with single-clock spikes at every mid-bit.
    clear(4);
    for (int j = 0; j < NNOISE; j++) noise_bytes[j] = 8'($urandom_range(0, 255));
    for (int j = 0; j < NNOISE; j++) send_8n1(4, 16, noise_bytes[j], 1'b1);
    tick(40);
    check("noise count", 32'(got_n[4]), 32'(NNOISE));
    for (int j = 0; j < NNOISE && j < got_n[4]; j++)
      check($sformatf("noise word%0d", j), 32'(got[4][j]), 32'({2'b00, noise_bytes[j]}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
